// File: rtl/chip_tx_scheduler.sv
// rtl/chip_tx_scheduler.sv - round-robin injection scheduler for the chip connection port
// Wormhole locks keep each connect's packet contiguous; occupancy counters guard the mux-in buffers.
module chip_tx_scheduler #(
  parameter  int FW      = 64,
  parameter  int B       = 4,
  parameter  int CONNECT = 2,
  parameter  int NREQ    = 4,
  localparam int CW      = (CONNECT > 1) ? $clog2(CONNECT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [FW*NREQ-1:0]   req_flit,
  input  logic [CW*NREQ-1:0]   req_dest,
  input  logic [NREQ-1:0]      req_tail,
  input  logic [CONNECT-1:0]   connect_available,
  input  logic [CONNECT-1:0]   connect_drain,
  output logic                 data_in_wr,
  output logic [FW+CW-1:0]     data_in,
  output logic                 proto_err
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 1 << B;
  localparam logic [B:0] DEPTH_V = (B+1)'(DEPTH);

  logic [B:0]        occ_q      [CONNECT];
  logic [B:0]        occ_d      [CONNECT];
  logic [CONNECT-1:0] lock_v_q, lock_v_d;
  logic [RW-1:0]     lock_own_q [CONNECT];
  logic [RW-1:0]     lock_own_d [CONNECT];
  logic [RW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              data_in_wr_q, data_in_wr_d;
  logic [FW+CW-1:0]  data_in_q, data_in_d;
  logic              proto_err_q, proto_err_d;

  logic [CW-1:0]     dest [NREQ];
  logic [NREQ-1:0]   dest_ok;
  logic [NREQ-1:0]   own_other;
  logic [NREQ-1:0]   elig;
  logic              gnt_found;
  logic [RW-1:0]     gnt_idx;
  logic [CW-1:0]     gnt_dest;
  logic              gnt_tail;
  logic [FW-1:0]     gnt_flit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CONNECT; c++) begin
        occ_q[c]      <= '0;
        lock_own_q[c] <= '0;
      end
      lock_v_q     <= '0;
      rr_ptr_q     <= '0;
      data_in_wr_q <= 1'b0;
      data_in_q    <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      for (int c = 0; c < CONNECT; c++) begin
        occ_q[c]      <= occ_d[c];
        lock_own_q[c] <= lock_own_d[c];
      end
      lock_v_q     <= lock_v_d;
      rr_ptr_q     <= rr_ptr_d;
      data_in_wr_q <= data_in_wr_d;
      data_in_q    <= data_in_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Eligibility and round-robin grant (output logic)
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      dest[i]      = (CONNECT == 1) ? '0 : req_dest[i*CW +: CW];
      dest_ok[i]   = int'(dest[i]) < CONNECT;
      own_other[i] = 1'b0;
      for (int c = 0; c < CONNECT; c++) begin
        if (lock_v_q[c] && lock_own_q[c] == RW'(i) && CW'(c) != dest[i])
          own_other[i] = 1'b1;
      end
      elig[i] = req_valid[i] && dest_ok[i] && !own_other[i] &&
                connect_available[dest[i]] && (occ_q[dest[i]] < DEPTH_V) &&
                (!lock_v_q[dest[i]] || lock_own_q[dest[i]] == RW'(i));
    end
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = RW'(idx);
      end
    end
    gnt_dest  = dest[gnt_idx];
    gnt_tail  = req_tail[gnt_idx];
    gnt_flit  = req_flit[int'(gnt_idx)*FW +: FW];
    req_ready = (gnt_found && rst_n) ? (NREQ'(1) << gnt_idx) : '0;
  end

  // Lock next-state, occupancy, pointer and error tracking
  always_comb begin
    lock_v_d    = lock_v_q;
    proto_err_d = proto_err_q | (|(req_valid & own_other));
    for (int c = 0; c < CONNECT; c++) begin
      logic inc, dec;
      lock_own_d[c] = lock_own_q[c];
      occ_d[c]      = occ_q[c];
      inc = gnt_found && (gnt_dest == CW'(c));
      dec = connect_drain[c];
      if (inc) begin
        if (!gnt_tail) begin
          lock_v_d[c]   = 1'b1;
          lock_own_d[c] = gnt_idx;
        end else begin
          lock_v_d[c]   = 1'b0;
        end
      end
      // A drain with nothing buffered is an error even if a grant lands the same cycle
      if (dec && occ_q[c] == '0)
        proto_err_d = 1'b1;
      if (inc && !dec) begin
        if (occ_q[c] == DEPTH_V) proto_err_d = 1'b1;
        else                     occ_d[c] = occ_q[c] + 1'b1;
      end else if (dec && !inc) begin
        if (occ_q[c] != '0)      occ_d[c] = occ_q[c] - 1'b1;
      end
    end
    rr_ptr_d     = gnt_found ? RW'((int'(gnt_idx) + 1) % NREQ) : rr_ptr_q;
    data_in_wr_d = gnt_found;
    data_in_d    = gnt_found ? {gnt_dest, gnt_flit} : data_in_q;
  end

  assign data_in_wr = data_in_wr_q;
  assign data_in    = data_in_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_chip_tx_scheduler.sv
// tb/tb_chip_tx_scheduler.sv - directed self-checking bench for chip_tx_scheduler
module tb_chip_tx_scheduler;

  localparam int FW = 64;
  localparam int CONNECT = 2;
  localparam int NREQ = 4;
  localparam int CW = 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [FW*NREQ-1:0]  req_flit;
  logic [CW*NREQ-1:0]  req_dest;
  logic [NREQ-1:0]     req_tail;
  logic [CONNECT-1:0]  connect_available;
  logic [CONNECT-1:0]  connect_drain;
  logic                data_in_wr;
  logic [FW+CW-1:0]    data_in;
  logic                proto_err;

  always #5 clk = ~clk;

  chip_tx_scheduler #(.FW(FW), .B(4), .CONNECT(CONNECT), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
    .req_dest(req_dest), .req_tail(req_tail),
    .connect_available(connect_available), .connect_drain(connect_drain),
    .data_in_wr(data_in_wr), .data_in(data_in), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_fail = 0;
  int rem [NREQ];
  int sent[NREQ];
  int pos [NREQ];
  int plen[NREQ];
  logic [CW-1:0] dst[NREQ];

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] flit_of(int i);
    return {8'(8'hA0 + i), 24'h0, 32'(sent[i])};
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = rem[i] > 0;
      req_dest[i*CW +: CW]   = dst[i];
      req_tail[i]            = (pos[i] == plen[i] - 1);
      req_flit[i*FW +: FW]   = flit_of(i);
    end
  endtask

  task automatic cycle(output logic [NREQ-1:0] g);
    drive();
    #1;
    g = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        rem[i]--;
        sent[i]++;
        pos[i] = (pos[i] + 1) % plen[i];
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; sent[i] = 0; pos[i] = 0; plen[i] = 1; dst[i] = '0;
    end
    connect_available = '1;
    connect_drain = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0] g;
  logic [3:0] exp4;
  logic [3:0] seq3 [6];
  int cnt;

  initial begin
    // Reset state, with requests present to prove req_ready is gated
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 1; sent[i] = 0; pos[i] = 0; plen[i] = 1; dst[i] = '0;
    end
    connect_available = '1;
    connect_drain = '0;
    drive();
    #3;
    check_eq("rst_ready", 72'(req_ready), 72'h0);
    check_eq("rst_wr", 72'(data_in_wr), 72'h0);
    check_eq("rst_data", 72'(data_in), 72'h0);
    check_eq("rst_err", 72'(proto_err), 72'h0);

    // 1: single requester to connect 1
    do_reset();
    rem[0] = 1; dst[0] = 1'b1;
    cycle(g);
    check_eq("t1_ready", 72'(g), 72'h1);
    check_eq("t1_wr", 72'(data_in_wr), 72'h1);
    check_eq("t1_data", 72'(data_in), 72'h1_A000_0000_0000_0000);
    check_eq("t1_occ1", 72'(dut.occ_q[1]), 72'h1);
    cycle(g);
    check_eq("t1_idle_ready", 72'(g), 72'h0);
    check_eq("t1_idle_wr", 72'(data_in_wr), 72'h0);
    check_eq("t1_hold_data", 72'(data_in), 72'h1_A000_0000_0000_0000);
    check_eq("t1_err", 72'(proto_err), 72'h0);

    // 2: four requesters to connect 0, round-robin order
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 2; dst[i] = 1'b0;
    end
    connect_drain = 2'b01;
    for (int k = 0; k < 8; k++) begin
      cycle(g);
      exp4 = 4'b0001 << (k % 4);
      check_eq($sformatf("t2_grant%0d", k), 72'(g), 72'(exp4));
    end
    connect_drain = '0;

    // 3: wormhole lock on connect 0, connect 1 interleaves
    do_reset();
    plen[0] = 3; rem[0] = 3; dst[0] = 1'b0;
    rem[1] = 1; dst[1] = 1'b0;
    rem[2] = 2; dst[2] = 1'b1;
    seq3[0] = 4'b0001; seq3[1] = 4'b0100; seq3[2] = 4'b0001;
    seq3[3] = 4'b0100; seq3[4] = 4'b0001; seq3[5] = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      cycle(g);
      check_eq($sformatf("t3_grant%0d", k), 72'(g), 72'(seq3[k]));
      if (k == 1)
        check_eq("t3_data_req2", 72'(data_in), 72'h1_A200_0000_0000_0000);
    end

    // 4: occupancy limit on connect 1 without drain
    do_reset();
    rem[0] = 100; dst[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(g);
      if (g[0]) cnt++;
    end
    check_eq("t4_grants_full", 72'(cnt), 72'd16);
    #1;
    check_eq("t4_ready_full", 72'(req_ready), 72'h0);
    connect_drain = 2'b10;
    cycle(g);
    check_eq("t4_drain_cycle", 72'(g), 72'h0);
    connect_drain = '0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(g);
      if (g[0]) cnt++;
    end
    check_eq("t4_grants_after_drain", 72'(cnt), 72'd1);
    check_eq("t4_err", 72'(proto_err), 72'h0);

    // 5: connect credit gating
    do_reset();
    connect_available = 2'b10;
    rem[0] = 1; dst[0] = 1'b0;
    rem[1] = 1; dst[1] = 1'b1;
    cycle(g);
    check_eq("t5_only_req1", 72'(g), 72'h2);
    cycle(g);
    check_eq("t5_req0_blocked", 72'(g), 72'h0);
    connect_available = 2'b11;
    cycle(g);
    check_eq("t5_req0_released", 72'(g), 72'h1);

    // 6: asynchronous reset mid-packet clears lock and occupancy
    do_reset();
    plen[0] = 8; rem[0] = 5; dst[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(g);
      if (g[0]) cnt++;
    end
    check_eq("t6_grants", 72'(cnt), 72'd5);
    check_eq("t6_occ5", 72'(dut.occ_q[0]), 72'd5);
    check_eq("t6_locked", 72'(dut.lock_v_q[0]), 72'h1);
    rem[0] = 1;
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_wr", 72'(data_in_wr), 72'h0);
    check_eq("t6_rst_ready", 72'(req_ready), 72'h0);
    check_eq("t6_rst_occ", 72'(dut.occ_q[0]), 72'h0);
    check_eq("t6_rst_lock", 72'(dut.lock_v_q[0]), 72'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rem[0] = 0;
    rem[1] = 1; dst[1] = 1'b0;
    cycle(g);
    check_eq("t6_other_granted", 72'(g), 72'h2);

    // 6b: drain at zero occupancy sets a sticky error
    do_reset();
    connect_drain = 2'b01;
    cycle(g);
    connect_drain = '0;
    check_eq("t6b_err_set", 72'(proto_err), 72'h1);
    repeat (3) cycle(g);
    check_eq("t6b_err_sticky", 72'(proto_err), 72'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
